// File: rtl/request_block_rr_pe_if.sv
// Bus bundle between the request block, its N_CH masters and the single slave port.
//
// Handshake semantics (both sides):
//   Upstream:   a request from master i is transferred in the cycle where
//               data_req_i[i] && data_gnt_o[i]. A master keeps its request and
//               payload stable until it sees the grant.
//   Downstream: a request is transferred to the slave in the cycle where
//               data_req_o && data_gnt_i. The block keeps data_req_o and the
//               payload stable until the slave grants.
//   Response:   data_r_valid_i with a one-hot data_r_ID_i completes one
//               earlier request of the addressed master. There is no backpressure.
interface request_block_rr_pe_if #(
    parameter int N_CH       = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
);
    // master side
    logic [N_CH-1:0]                 data_req_i;
    logic [N_CH-1:0][ADDR_WIDTH-1:0] data_add_i;
    logic [N_CH-1:0]                 data_wen_i;
    logic [N_CH-1:0][5:0]            data_atop_i;
    logic [N_CH-1:0][DATA_WIDTH-1:0] data_wdata_i;
    logic [N_CH-1:0][BE_WIDTH-1:0]   data_be_i;
    logic [N_CH-1:0]                 data_gnt_o;
    logic [N_CH-1:0]                 data_r_valid_o;

    // slave side
    logic                  data_req_o;
    logic [ADDR_WIDTH-1:0] data_add_o;
    logic                  data_wen_o;
    logic [5:0]            data_atop_o;
    logic [DATA_WIDTH-1:0] data_wdata_o;
    logic [BE_WIDTH-1:0]   data_be_o;
    logic [N_CH-1:0]       data_ID_o;
    logic                  data_gnt_i;
    logic                  data_r_valid_i;
    logic [N_CH-1:0]       data_r_ID_i;

    // view taken by the request block itself
    modport slave (
        input  data_req_i, data_add_i, data_wen_i, data_atop_i, data_wdata_i, data_be_i,
        input  data_gnt_i, data_r_valid_i, data_r_ID_i,
        output data_gnt_o, data_r_valid_o,
        output data_req_o, data_add_o, data_wen_o, data_atop_o, data_wdata_o, data_be_o,
        output data_ID_o
    );

    // view taken by the environment around the block (masters and slave)
    modport master (
        output data_req_i, data_add_i, data_wen_i, data_atop_i, data_wdata_i, data_be_i,
        output data_gnt_i, data_r_valid_i, data_r_ID_i,
        input  data_gnt_o, data_r_valid_o,
        input  data_req_o, data_add_o, data_wen_o, data_atop_o, data_wdata_o, data_be_o,
        input  data_ID_o
    );
endinterface

// File: rtl/request_block_rr_pe.sv
// N-master request block: round-robin arbitration of N_CH request channels onto
// one slave port, optional single-entry output slice, per-master outstanding
// limits and one-hot response routing.
module request_block_rr_pe #(
    parameter int N_CH            = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BE_WIDTH        = DATA_WIDTH / 8,
    parameter int MAX_OUTSTANDING = 2,
    parameter int PIPE_REQ        = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    request_block_rr_pe_if.slave  bus,
    output logic                  busy_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int RR_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    // cyclic index base+k, both operands already below N_CH
    function automatic int wrap_idx(input int base, input int k);
        int s;
        s = base + k;
        return (s >= N_CH) ? s - N_CH : s;
    endfunction

    logic [RR_W-1:0]       rr_q;
    logic [RR_W-1:0]       cand;
    logic [RR_W-1:0]       winner;
    logic                  any_elig;
    logic [N_CH-1:0]       eligible;
    logic [N_CH-1:0]       win_oh;
    logic [N_CH-1:0]       gnt;
    logic [N_CH-1:0]       hs;
    logic                  hs_any;
    logic [N_CH-1:0]       dec;
    logic [N_CH-1:0]       cnt_nz;
    logic [N_CH-1:0]       dec_at_zero;
    logic [CNT_W-1:0]      cnt_q [N_CH];
    logic                  slice_ready;
    logic                  grant_ok;
    logic                  valid_q;
    logic                  rst_q;

    logic [ADDR_WIDTH-1:0] sel_add;
    logic                  sel_wen;
    logic [5:0]            sel_atop;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [BE_WIDTH-1:0]   sel_be;

    // eligibility: requesting and still below the outstanding limit
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_CH; i++) begin
            eligible[i] = bus.data_req_i[i] && (cnt_q[i] < CNT_MAX);
        end
    end

    // winner: first eligible index at or after rr_q, then its payload
    always_comb begin
        cand      = '0;
        winner    = '0;
        any_elig  = 1'b0;
        win_oh    = '0;
        sel_add   = '0;
        sel_wen   = 1'b0;
        sel_atop  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int k = 0; k < N_CH; k++) begin
            cand = RR_W'(wrap_idx(int'(rr_q), k));
            if (!any_elig && eligible[cand]) begin
                any_elig = 1'b1;
                winner   = cand;
            end
        end
        if (any_elig) begin
            win_oh[winner] = 1'b1;
            sel_add        = bus.data_add_i[winner];
            sel_wen        = bus.data_wen_i[winner];
            sel_atop       = bus.data_atop_i[winner];
            sel_wdata      = bus.data_wdata_i[winner];
            sel_be         = bus.data_be_i[winner];
        end
    end

    // grant goes only to the winner; the slave grant or free slice gates it
    assign grant_ok        = (PIPE_REQ != 0) ? slice_ready : bus.data_gnt_i;
    assign gnt             = win_oh & {N_CH{grant_ok}};
    assign hs              = gnt & bus.data_req_i;
    assign hs_any          = |hs;
    assign bus.data_gnt_o  = gnt;

    // response routing is purely combinational
    assign dec                = bus.data_r_ID_i & {N_CH{bus.data_r_valid_i}};
    assign bus.data_r_valid_o = dec;

    // round-robin pointer moves just past the master that handshook
    generate
        if (N_CH == 1) begin : g_rr_single
            assign rr_q = '0;
        end else begin : g_rr_multi
            always_ff @(posedge clk) begin
                if (rst) begin
                    rr_q <= '0;
                end else if (hs_any) begin
                    rr_q <= (winner == RR_W'(N_CH - 1)) ? '0 : winner + RR_W'(1);
                end
            end
        end
    endgenerate

    // outstanding counters: +1 on handshake, -1 on response, both cancel out
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (rst) begin
                cnt_q[i] <= '0;
            end else if (hs[i] && !dec[i]) begin
                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end else if (dec[i] && !hs[i] && cnt_q[i] != '0) begin
                cnt_q[i] <= cnt_q[i] - CNT_W'(1);
            end
        end
    end

    // per-master status flags for busy and the underflow check
    always_comb begin
        cnt_nz      = '0;
        dec_at_zero = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_nz[i]      = (cnt_q[i] != '0);
            dec_at_zero[i] = dec[i] && !hs[i] && (cnt_q[i] == '0);
        end
    end

    assign busy_o = valid_q || (|cnt_nz);

    // remembers the reset cycle so stale responses right after it are tolerated
    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    // a response for a master with nothing outstanding is a protocol error
    a_no_underflow: assert property (@(posedge clk) disable iff (rst || rst_q)
                                     (dec_at_zero == '0));

    generate
        if (PIPE_REQ != 0) begin : g_slice
            logic                  valid_r;
            logic [ADDR_WIDTH-1:0] add_r;
            logic                  wen_r;
            logic [5:0]            atop_r;
            logic [DATA_WIDTH-1:0] wdata_r;
            logic [BE_WIDTH-1:0]   be_r;
            logic [N_CH-1:0]       id_r;

            assign slice_ready = !valid_r || bus.data_gnt_i;

            // single-entry slice: capture on handshake, drain on slave grant
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_r <= 1'b0;
                    add_r   <= '0;
                    wen_r   <= 1'b0;
                    atop_r  <= '0;
                    wdata_r <= '0;
                    be_r    <= '0;
                    id_r    <= '0;
                end else if (hs_any) begin
                    valid_r <= 1'b1;
                    add_r   <= sel_add;
                    wen_r   <= sel_wen;
                    atop_r  <= sel_atop;
                    wdata_r <= sel_wdata;
                    be_r    <= sel_be;
                    id_r    <= win_oh;
                end else if (bus.data_gnt_i && valid_r) begin
                    valid_r <= 1'b0;
                end
            end

            assign valid_q          = valid_r;
            assign bus.data_req_o   = valid_r;
            assign bus.data_add_o   = add_r;
            assign bus.data_wen_o   = wen_r;
            assign bus.data_atop_o  = atop_r;
            assign bus.data_wdata_o = wdata_r;
            assign bus.data_be_o    = be_r;
            assign bus.data_ID_o    = id_r;
        end else begin : g_comb
            assign slice_ready      = 1'b1;
            assign valid_q          = 1'b0;
            assign bus.data_req_o   = any_elig;
            assign bus.data_add_o   = sel_add;
            assign bus.data_wen_o   = sel_wen;
            assign bus.data_atop_o  = sel_atop;
            assign bus.data_wdata_o = sel_wdata;
            assign bus.data_be_o    = sel_be;
            assign bus.data_ID_o    = win_oh;
        end
    endgenerate

endmodule

// File: tb/tb_request_block_rr_pe.sv
// Bench for request_block_rr_pe: a 4-master sliced instance and a 3-master
// combinational instance, directed stimulus, a cycle-by-cycle reference model
// and hand-computed expectations for the notable cases.
module tb_request_block_rr_pe;

    localparam int MAXO = 2;

    logic clk;
    logic rst;
    logic busy4;
    logic busy3;

    request_block_rr_pe_if #(.N_CH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4)) b4 ();
    request_block_rr_pe_if #(.N_CH(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4)) b3 ();

    request_block_rr_pe #(
        .N_CH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4),
        .MAX_OUTSTANDING(MAXO), .PIPE_REQ(1)
    ) dut4 (
        .clk    (clk),
        .rst    (rst),
        .bus    (b4),
        .busy_o (busy4)
    );

    request_block_rr_pe #(
        .N_CH(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4),
        .MAX_OUTSTANDING(MAXO), .PIPE_REQ(0)
    ) dut3 (
        .clk    (clk),
        .rst    (rst),
        .bus    (b3),
        .busy_o (busy3)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- counters and compare helper ----------------
    int total = 0;
    int bad   = 0;
    logic chk_on = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- response source for dut4 ----------------
    logic       auto_resp = 1'b0;
    logic       resp_v    = 1'b0;
    logic [3:0] resp_id   = 4'b0;
    logic       man_v     = 1'b0;
    logic [3:0] man_id    = 4'b0;
    logic       acc;
    logic [3:0] acc_id;

    assign b4.data_r_valid_i = auto_resp ? resp_v  : man_v;
    assign b4.data_r_ID_i    = auto_resp ? resp_id : man_id;

    // answers each slave-accepted request one cycle later
    always @(negedge clk) begin
        acc    = b4.data_req_o && b4.data_gnt_i;
        acc_id = b4.data_ID_o;
        @(posedge clk);
        #2;
        resp_v  = acc;
        resp_id = acc ? acc_id : 4'b0;
    end

    // ---------------- reference model ----------------
    logic [78:0] exp_q[$];
    int          m4_cnt[4] = '{default: 0};
    int          m3_cnt[4] = '{default: 0};
    int          m4_rr = 0;
    int          m3_rr = 0;
    int          w4, w3;
    logic [3:0]  eg4, eg3;
    logic        rdy4;
    logic [1:0]  wi;
    logic        inc, dec;

    // first requester with room, scanning cyclically from the pointer
    function automatic int pick(input logic [3:0] req, input int cnt[4], input int rr, input int n);
        for (int k = 0; k < n; k++) begin
            int j;
            j = (rr + k) % n;
            if (req[j] && cnt[j] < MAXO) return j;
        end
        return -1;
    endfunction

    function automatic logic any_nz(input int cnt[4]);
        return (cnt[0] != 0) || (cnt[1] != 0) || (cnt[2] != 0) || (cnt[3] != 0);
    endfunction

    // compares both instances against the model every cycle, then advances it
    always @(negedge clk) begin
        if (chk_on) begin
            // 4-master sliced instance
            w4   = pick(b4.data_req_i, m4_cnt, m4_rr, 4);
            rdy4 = (exp_q.size() == 0) || b4.data_gnt_i;
            eg4  = (w4 >= 0 && rdy4) ? (4'b0001 << w4) : 4'b0000;
            chk("m4_gnt", b4.data_gnt_o, eg4);
            chk("m4_req", b4.data_req_o, exp_q.size() != 0);
            if (exp_q.size() != 0)
                chk("m4_payload", {b4.data_ID_o, b4.data_atop_o, b4.data_wen_o, b4.data_be_o,
                                   b4.data_wdata_o, b4.data_add_o}, exp_q[0]);
            chk("m4_rvalid", b4.data_r_valid_o, b4.data_r_valid_i ? b4.data_r_ID_i : 4'b0000);
            chk("m4_busy", busy4, (exp_q.size() != 0) || any_nz(m4_cnt));

            // 3-master combinational instance
            w3  = pick({1'b0, b3.data_req_i}, m3_cnt, m3_rr, 3);
            eg3 = (w3 >= 0 && b3.data_gnt_i) ? (4'b0001 << w3) : 4'b0000;
            chk("m3_gnt", {1'b0, b3.data_gnt_o}, eg3);
            chk("m3_req", b3.data_req_o, w3 >= 0);
            if (w3 >= 0) begin
                wi = 2'(w3);
                chk("m3_payload", {b3.data_ID_o, b3.data_atop_o, b3.data_wen_o, b3.data_be_o,
                                   b3.data_wdata_o, b3.data_add_o},
                    {3'(4'b0001 << w3), b3.data_atop_i[wi], b3.data_wen_i[wi], b3.data_be_i[wi],
                     b3.data_wdata_i[wi], b3.data_add_i[wi]});
            end
            chk("m3_rvalid", {1'b0, b3.data_r_valid_o},
                b3.data_r_valid_i ? {1'b0, b3.data_r_ID_i} : 4'b0000);
            chk("m3_busy", busy3, any_nz(m3_cnt));

            // advance the model to the state after the coming edge
            if (rst) begin
                exp_q.delete();
                m4_cnt = '{default: 0};
                m3_cnt = '{default: 0};
                m4_rr  = 0;
                m3_rr  = 0;
            end else begin
                if (exp_q.size() != 0 && b4.data_gnt_i) void'(exp_q.pop_front());
                if (eg4 != 4'b0000) begin
                    wi = 2'(w4);
                    exp_q.push_back({eg4, b4.data_atop_i[wi], b4.data_wen_i[wi], b4.data_be_i[wi],
                                     b4.data_wdata_i[wi], b4.data_add_i[wi]});
                    m4_rr = (w4 + 1) % 4;
                end
                if (eg3 != 4'b0000) m3_rr = (w3 + 1) % 3;
                for (int i = 0; i < 4; i++) begin
                    inc = eg4[i];
                    dec = b4.data_r_valid_i && b4.data_r_ID_i[i];
                    if (inc && !dec) m4_cnt[i]++;
                    else if (dec && !inc && m4_cnt[i] > 0) m4_cnt[i]--;
                end
                for (int i = 0; i < 3; i++) begin
                    inc = eg3[i];
                    dec = b3.data_r_valid_i && b3.data_r_ID_i[i];
                    if (inc && !dec) m3_cnt[i]++;
                    else if (dec && !inc && m3_cnt[i] > 0) m3_cnt[i]--;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    logic [3:0] seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                            4'b0001, 4'b0010, 4'b0100, 4'b1000};
    int ng;

    initial begin
        rst = 1'b1;
        b4.data_req_i   = '0;
        b4.data_gnt_i   = 1'b0;
        b3.data_req_i   = '0;
        b3.data_gnt_i   = 1'b0;
        b3.data_r_valid_i = 1'b0;
        b3.data_r_ID_i  = '0;
        for (int i = 0; i < 4; i++) begin
            b4.data_add_i[2'(i)]   = 32'h1000_0000 + 32'(i * 16);
            b4.data_wdata_i[2'(i)] = 32'hA000_0000 + 32'(i);
            b4.data_be_i[2'(i)]    = 4'hF - 4'(i);
            b4.data_wen_i[2'(i)]   = i[0];
            b4.data_atop_i[2'(i)]  = 6'(i + 1);
        end
        for (int i = 0; i < 3; i++) begin
            b3.data_add_i[2'(i)]   = 32'h3000_0000 + 32'(i);
            b3.data_wdata_i[2'(i)] = 32'hB000_0000 + 32'(i);
            b3.data_be_i[2'(i)]    = 4'(i + 3);
            b3.data_wen_i[2'(i)]   = ~i[0];
            b3.data_atop_i[2'(i)]  = 6'(i + 8);
        end
        repeat (2) next_cycle();
        rst = 1'b0;
        chk_on = 1'b1;

        // reset state, three idle cycles
        repeat (3) mid();
        chk("t1_req4", b4.data_req_o, 1'b0);
        chk("t1_gnt4", b4.data_gnt_o, 4'b0000);
        chk("t1_busy4", busy4, 1'b0);
        chk("t1_id4", b4.data_ID_o, 4'b0000);
        chk("t1_req3", b3.data_req_o, 1'b0);
        chk("t1_id3", b3.data_ID_o, 3'b000);
        next_cycle();

        // all four masters, slave always granting, responses one cycle later
        auto_resp     = 1'b1;
        b4.data_req_i = 4'b1111;
        b4.data_gnt_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            mid();
            chk("t2_gnt_order", b4.data_gnt_o, seq[c]);
            if (c > 0) begin
                chk("t2_id_lag", b4.data_ID_o, seq[c-1]);
                chk("t2_req_o", b4.data_req_o, 1'b1);
            end
            next_cycle();
        end
        b4.data_req_i = 4'b0000;
        repeat (4) next_cycle();
        auto_resp = 1'b0;
        man_v     = 1'b0;
        man_id    = 4'b0000;
        mid();
        chk("t2_drained", busy4, 1'b0);
        next_cycle();

        // master 2 alone hits the outstanding limit, a response releases it
        b4.data_req_i = 4'b0100;
        ng = 0;
        for (int c = 0; c < 4; c++) begin
            mid();
            if (b4.data_gnt_o[2]) ng++;
            next_cycle();
        end
        chk("t3_grant_count", 32'(ng), 32'd2);
        man_v  = 1'b1;
        man_id = 4'b0100;
        mid();
        chk("t3_rvalid_route", b4.data_r_valid_o, 4'b0100);
        chk("t3_still_blocked", b4.data_gnt_o, 4'b0000);
        next_cycle();
        man_v  = 1'b0;
        man_id = 4'b0000;
        mid();
        chk("t3_regranted", b4.data_gnt_o, 4'b0100);
        next_cycle();
        b4.data_req_i = 4'b0000;
        man_v  = 1'b1;
        man_id = 4'b0100;
        repeat (2) next_cycle();
        man_v  = 1'b0;
        man_id = 4'b0000;
        mid();
        chk("t3_idle", busy4, 1'b0);
        next_cycle();

        // slave stalls: slice holds master 1's request stable
        b4.data_req_i     = 4'b0010;
        b4.data_add_i[1]  = 32'h1000_0040;
        b4.data_gnt_i     = 1'b0;
        mid();
        chk("t4_first_gnt", b4.data_gnt_o, 4'b0010);
        chk("t4_req_latency", b4.data_req_o, 1'b0);
        next_cycle();
        b4.data_add_i[1] = 32'h2222_2222;
        for (int c = 0; c < 5; c++) begin
            mid();
            chk("t4_req_held", b4.data_req_o, 1'b1);
            chk("t4_add_held", b4.data_add_o, 32'h1000_0040);
            chk("t4_id_held", b4.data_ID_o, 4'b0010);
            chk("t4_no_gnt", b4.data_gnt_o, 4'b0000);
            next_cycle();
        end
        b4.data_req_i = 4'b0000;
        b4.data_gnt_i = 1'b1;
        mid();
        chk("t4_req_at_release", b4.data_req_o, 1'b1);
        next_cycle();
        man_v  = 1'b1;
        man_id = 4'b0010;
        mid();
        chk("t4_slice_empty", b4.data_req_o, 1'b0);
        next_cycle();
        man_v  = 1'b0;
        man_id = 4'b0000;

        // handshake and response for master 0 in the same cycle
        b4.data_req_i = 4'b0001;
        mid();
        chk("t5_gnt_a", b4.data_gnt_o, 4'b0001);
        next_cycle();
        man_v  = 1'b1;
        man_id = 4'b0001;
        mid();
        chk("t5_gnt_b", b4.data_gnt_o, 4'b0001);
        next_cycle();
        man_v  = 1'b0;
        man_id = 4'b0000;
        mid();
        chk("t5_gnt_c", b4.data_gnt_o, 4'b0001);
        next_cycle();
        mid();
        chk("t5_blocked", b4.data_gnt_o, 4'b0000);
        next_cycle();
        b4.data_req_i = 4'b0000;
        man_v  = 1'b1;
        man_id = 4'b0001;
        repeat (2) next_cycle();
        man_v  = 1'b0;
        man_id = 4'b0000;
        mid();
        chk("t5_idle", busy4, 1'b0);
        next_cycle();

        // three masters, no slice: wrap-around and reset mid-burst
        b3.data_gnt_i = 1'b1;
        b3.data_req_i = 3'b010;
        mid();
        chk("t6_gnt_m1", b3.data_gnt_o, 3'b010);
        next_cycle();
        b3.data_req_i = 3'b011;
        mid();
        chk("t6_wrap_gnt", b3.data_gnt_o, 3'b001);
        chk("t6_wrap_id", b3.data_ID_o, 3'b001);
        chk("t6_wrap_req", b3.data_req_o, 1'b1);
        chk("t6_wrap_add", b3.data_add_o, 32'h3000_0000);
        next_cycle();
        mid();
        chk("t6_ptr_1", b3.data_gnt_o, 3'b010);
        next_cycle();
        mid();
        chk("t6_ptr_2", b3.data_gnt_o, 3'b001);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        b3.data_req_i = 3'b000;
        mid();
        chk("t6_rst_req", b3.data_req_o, 1'b0);
        chk("t6_rst_busy", busy3, 1'b0);
        chk("t6_rst_gnt", b3.data_gnt_o, 3'b000);
        next_cycle();
        b3.data_req_i = 3'b011;
        mid();
        chk("t6_after_rst", b3.data_gnt_o, 3'b001);
        next_cycle();
        b3.data_req_i     = 3'b000;
        b3.data_r_valid_i = 1'b1;
        b3.data_r_ID_i    = 3'b001;
        next_cycle();
        b3.data_r_valid_i = 1'b0;
        b3.data_r_ID_i    = 3'b000;
        mid();
        chk("t6_final_idle", busy3, 1'b0);
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
